// File: rtl/gppm_pkg.sv
// Shared definitions for the GPPM micro-sequencer: FSM states, control codes
// and the bit positions of the strobe, control and branch-target fields.
package gppm_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Control codes carried in the upper bits of every program word
  localparam logic [1:0] CTL_NEXT = 2'b00;
  localparam logic [1:0] CTL_JZ   = 2'b01;
  localparam logic [1:0] CTL_JMP  = 2'b10;
  localparam logic [1:0] CTL_HALT = 2'b11;

  // Field positions inside a 64-bit program word
  localparam int STROBE_BIT = 0;
  localparam int CTL_LSB    = 54;
  localparam int CTL_MSB    = 55;
  localparam int TGT_LSB    = 56;
  localparam int TGT_MSB    = 63;

  // Extract the control code from a program word
  function automatic logic [1:0] get_ctl(input logic [63:0] word);
    return word[CTL_MSB:CTL_LSB];
  endfunction

endpackage

// File: rtl/gppm_prog_mem.sv
// Program memory: DEPTH x 64 words, one write port and one registered read
// port. The read register doubles as the word latch seen by the datapath, so
// it can be cleared and held; a same-cycle write to the address being read
// is forwarded so a run started together with a load sees the new word.
module gppm_prog_mem
  #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
  )
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [63:0]       wdata,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [63:0]       rdata
  );

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // Storage array write; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read with clear/hold and write-to-read forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 64'd0;
    end else if (clr) begin
      rdata_q <= 64'd0;
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_q <= wdata;
      end else begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/gppm_sequencer.sv
// GPPM micro-sequencer: steps a stored program, issuing each word in two
// cycles (SETUP with strobe low, STROBE with strobe high) and resolving
// NEXT/JZ/JMP/HALT control codes.
// Optional feature macro: GPPM_SEQ_RETIRE_CNT_EN enables the 32-bit retired
// word counter; without it the retired port is tied to zero.
module gppm_sequencer
  import gppm_pkg::*;
  #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
  )
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [63:0]       load_data,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              is_zero,
    output logic [63:0]       instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [31:0]       retired
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              z_q, z_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              mem_we_s;
  logic              rd_en_s;
  logic              rd_clr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [63:0]       word_s;
  logic [1:0]        ctl_s;
  logic [ADDR_W-1:0] tgt_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              accept_start_s;
  logic              retire_s;
  logic              unused_bit0_s;

  // Loads are only honoured while idle
  assign mem_we_s       = (state_q == IDLE) && load_we;
  assign accept_start_s = (state_q == IDLE) && start;

  gppm_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en_s),
    .clr   (rd_clr_s),
    .raddr (rd_addr_s),
    .rdata (word_s)
  );

  assign ctl_s         = get_ctl(word_s);
  assign tgt_s         = word_s[TGT_LSB +: ADDR_W];
  assign pc_inc_s      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign unused_bit0_s = word_s[STROBE_BIT];

  // Next-state, next-PC and read-port control for the sequencer FSM
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    z_d       = z_q;
    rd_addr_s = pc_q;
    rd_en_s   = 1'b0;
    rd_clr_s  = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      IDLE: begin
        rd_addr_s = start_pc;
        if (start) begin
          state_d = SETUP;
          pc_d    = start_pc;
          rd_en_s = 1'b1;
        end else begin
          rd_clr_s = 1'b1;
        end
      end
      SETUP: begin
        // Flag reflects the current word's ALU result before its write commits
        z_d     = is_zero;
        state_d = STROBE;
      end
      STROBE: begin
        retire_s = 1'b1;
        case (ctl_s)
          CTL_NEXT: pc_d = pc_inc_s;
          CTL_JZ:   pc_d = z_q ? tgt_s : pc_inc_s;
          CTL_JMP:  pc_d = tgt_s;
          CTL_HALT: pc_d = pc_q;
          default:  pc_d = pc_inc_s;
        endcase
        if (ctl_s == CTL_HALT) begin
          state_d  = DONE;
          rd_clr_s = 1'b1;
        end else begin
          // Fetch the following word now so it is ready for its SETUP cycle
          state_d   = SETUP;
          rd_addr_s = pc_d;
          rd_en_s   = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rd_clr_s = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        rd_clr_s = 1'b1;
      end
    endcase
  end

  // Output flags are decoded from the upcoming state so they leave flops
  always_comb begin
    strobe_d = (state_d == STROBE);
    busy_d   = (state_d == SETUP) || (state_d == STROBE);
    done_d   = (state_d == DONE);
  end

  // FSM, PC, zero flag and output flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= {ADDR_W{1'b0}};
      z_q      <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      z_q      <= z_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef GPPM_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Retired-word count: cleared by a new run, bumped at the end of each STROBE
  always_comb begin
    retired_d = retired_q;
    if (accept_start_s) begin
      retired_d = 32'd0;
    end else if (retire_s) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // Retired counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = accept_start_s ^ retire_s;
  assign retired      = 32'd0;
`endif

  assign instruction = {word_s[63:1], strobe_q};
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_gppm_sequencer.sv
// Bench for gppm_sequencer. A trace model expands each run into the list of
// per-cycle outputs by walking the program array, and a compare process
// checks every cycle against it. is_zero is supplied by a per-address table
// standing in for the datapath's ALU result.
module tb_gppm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [63:0] load_data;
  logic [7:0]  start_pc;
  logic        is_zero;
  logic [63:0] instruction;
  logic [7:0]  pc;
  logic        busy;
  logic        done;
  logic [31:0] retired;

  gppm_sequencer #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start_pc    (start_pc),
    .is_zero     (is_zero),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] ins;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic [31:0] ret;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  idle_pc;
  logic [31:0] idle_ret;
  logic [63:0] mem_m [256];
  logic        zmap  [256];
  int          total;
  int          bad;
  int          cyc;
  int          start_cyc;
  int          done_at;
  bit          mon_en;
  logic [7:0]  obs_pc[$];
  logic        obs_b0[$];

  assign is_zero = zmap[pc];

  // Build a program word from control code, target and payload bits [53:1]
  function automatic logic [63:0] mk(input logic [1:0] ctl, input logic [7:0] tgt,
                                     input logic [52:0] pay);
    return {tgt, ctl, pay, 1'b0};
  endfunction

  function automatic logic [31:0] ret_exp(input int n);
`ifdef GPPM_SEQ_RETIRE_CNT_EN
    return n;
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expand a run from sp into expected per-cycle output records
  task automatic gen_run(input logic [7:0] sp);
    logic [7:0]  p;
    logic [63:0] w;
    int          n;
    rec_t        r;
    p = sp;
    n = 0;
    for (int steps = 0; steps < 300; steps++) begin
      w = mem_m[p];
      r.ins = {w[63:1], 1'b0}; r.pc = p; r.busy = 1'b1; r.done = 1'b0; r.ret = ret_exp(n);
      exp_q.push_back(r);
      r.ins = {w[63:1], 1'b1};
      exp_q.push_back(r);
      n++;
      if (w[55:54] == 2'b11) break;
      if (w[55:54] == 2'b10 || (w[55:54] == 2'b01 && zmap[p])) p = w[63:56];
      else p = p + 8'd1;
    end
    r.ins = 64'd0; r.pc = p; r.busy = 1'b0; r.done = 1'b1; r.ret = ret_exp(n);
    exp_q.push_back(r);
  endtask

  // Per-cycle compare against the model (idle values when no run is pending)
  initial begin
    rec_t r;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        idle_pc  = r.pc;
        idle_ret = r.ret;
      end else begin
        r.ins = 64'd0; r.pc = idle_pc; r.busy = 1'b0; r.done = 1'b0; r.ret = idle_ret;
      end
      chk("instruction", instruction, r.ins);
      chk("pc", {56'd0, pc}, {56'd0, r.pc});
      chk("busy", {63'd0, busy}, {63'd0, r.busy});
      chk("done", {63'd0, done}, {63'd0, r.done});
      chk("retired", {32'd0, retired}, {32'd0, r.ret});
      if (mon_en && busy === 1'b1) begin
        obs_pc.push_back(pc);
        obs_b0.push_back(instruction[0]);
      end
      if (mon_en && done === 1'b1 && done_at < 0) done_at = cyc;
    end
  end

  task automatic load_word(input logic [7:0] a, input logic [63:0] w);
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = a; load_data = w;
    @(posedge clk); #1;
    load_we = 1'b0;
    mem_m[a] = w;
  endtask

  task automatic start_run(input logic [7:0] sp, input bit do_load,
                           input logic [7:0] la, input logic [63:0] ld);
    @(posedge clk); #1;
    start = 1'b1; start_pc = sp;
    if (do_load) begin
      load_we = 1'b1; load_addr = la; load_data = ld;
    end
    @(posedge clk);
    if (do_load) mem_m[la] = ld;
    obs_pc.delete();
    obs_b0.delete();
    done_at   = -1;
    start_cyc = cyc;
    mon_en    = 1'b1;
    gen_run(sp);
    #1;
    start = 1'b0; load_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 600) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d records left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic chk_pc_seq(input string name, input logic [7:0] e [8], input int len);
    chk({name, "_len"}, 64'(obs_pc.size()), 64'(len));
    if (obs_pc.size() == len) begin
      for (int i = 0; i < len; i++) chk(name, {56'd0, obs_pc[i]}, {56'd0, e[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pcs [8];
    logic [63:0] halt_w;
    total = 0; bad = 0; mon_en = 1'b0; done_at = -1;
    idle_pc = 8'd0; idle_ret = 32'd0;
    rst_n = 1'b0; start = 1'b0; load_we = 1'b0;
    load_addr = 8'd0; load_data = 64'd0; start_pc = 8'd0;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 64'd0;
      zmap[i]  = 1'b0;
    end
    #1;
    chk("rst_instruction", instruction, 64'd0);
    chk("rst_pc", {56'd0, pc}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Program: write imm 5 to r1, write imm 5 to r2, HALT
    halt_w = mk(2'b11, 8'h00, 53'd0);
    load_word(8'd0, mk(2'b00, 8'h00, 53'h0_0000_0005_0011));
    load_word(8'd1, mk(2'b00, 8'h00, 53'h0_0000_0005_0012));
    load_word(8'd2, halt_w);

    // Straight line
    start_run(8'd0, 1'b0, 8'd0, 64'd0);
    wait_idle("straight");
    pcs = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    chk_pc_seq("straight_pc", pcs, 6);
    if (obs_b0.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("straight_bit0", {63'd0, obs_b0[i]}, 64'(i % 2));
    end
    chk("straight_done_lat", 64'(done_at - start_cyc), 64'd7);
`ifdef GPPM_SEQ_RETIRE_CNT_EN
    chk("straight_retired", {32'd0, retired}, 64'd3);
`else
    chk("straight_retired", {32'd0, retired}, 64'd0);
`endif

    // JZ taken (ALU result zero: r1 = r2 = 5) and not taken (r2 = 4)
    load_word(8'd3, mk(2'b01, 8'h10, 53'h0_0000_0000_0312));
    load_word(8'd4, halt_w);
    load_word(8'h10, halt_w);
    zmap[3] = 1'b1;
    start_run(8'd3, 1'b0, 8'd0, 64'd0);
    wait_idle("jz_taken");
    pcs = '{8'd3, 8'd3, 8'd16, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
    chk_pc_seq("jz_taken_pc", pcs, 4);
    zmap[3] = 1'b0;
    start_run(8'd3, 1'b0, 8'd0, 64'd0);
    wait_idle("jz_not_taken");
    pcs = '{8'd3, 8'd3, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    chk_pc_seq("jz_not_taken_pc", pcs, 4);

    // JMP with a target that also exercises the upper control bits
    load_word(8'd5, mk(2'b10, 8'h20, 53'h1_2345_6789_ABCD));
    load_word(8'h20, halt_w);
    start_run(8'd5, 1'b0, 8'd0, 64'd0);
    wait_idle("jmp");
    pcs = '{8'd5, 8'd5, 8'h20, 8'h20, 8'd0, 8'd0, 8'd0, 8'd0};
    chk_pc_seq("jmp_pc", pcs, 4);

    // Wrap from the last address
    load_word(8'd255, mk(2'b00, 8'h00, 53'h0_00FF_0000_0001));
    start_run(8'd255, 1'b0, 8'd0, 64'd0);
    wait_idle("wrap");
    pcs = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    chk_pc_seq("wrap_pc", pcs, 8);

    // Load and start in the same idle cycle: the new word runs
    load_word(8'd40, mk(2'b00, 8'h00, 53'h0_0000_0000_0040));
    start_run(8'd40, 1'b1, 8'd40, mk(2'b11, 8'h00, 53'h0_0000_0000_0BEE));
    wait_idle("load_start");
    chk("load_start_len", 64'(obs_pc.size()), 64'd2);
    chk("load_start_done_lat", 64'(done_at - start_cyc), 64'd3);

    // Busy guards: load and start while running are ignored
    start_run(8'd0, 1'b0, 8'd0, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    load_we = 1'b1; load_addr = 8'd1; load_data = 64'hDEAD_BEEF_0000_0000;
    start = 1'b1; start_pc = 8'h30;
    @(posedge clk); #1;
    load_we = 1'b0; start = 1'b0;
    wait_idle("busy_guard");
    pcs = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    chk_pc_seq("busy_guard_pc", pcs, 6);
    start_run(8'd0, 1'b0, 8'd0, 64'd0);
    wait_idle("busy_guard_rerun");
    chk_pc_seq("busy_guard_rerun_pc", pcs, 6);

    // Reset in the middle of STROBE
    start_run(8'd0, 1'b0, 8'd0, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    idle_pc = 8'd0; idle_ret = 32'd0; mon_en = 1'b0;
    #1;
    chk("midrst_instruction", instruction, 64'd0);
    chk("midrst_pc", {56'd0, pc}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_retired", {32'd0, retired}, 64'd0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("postrst_busy", {63'd0, busy}, 64'd0);
    chk("postrst_pc", {56'd0, pc}, 64'd0);
    start_run(8'd0, 1'b0, 8'd0, 64'd0);
    wait_idle("postrst_run");
    chk_pc_seq("postrst_pc_seq", pcs, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
